mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning the word-address width in bits (2**DEPTH words).
REQ-003 The block SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port if_req_i  input  1  instruction-fetch read request.
REQ-006 The block SHALL have port if_addr_i  input  DEPTH  fetch word address.
REQ-007 The block SHALL have port if_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 The block SHALL have port if_rvalid_o  output  1  fetch read data valid.
REQ-009 The block SHALL have port if_rdata_o  output  WIDTH  fetch read data.
REQ-010 The block SHALL have port d_req_i  input  1  data-port request.
REQ-011 The block SHALL have port d_we_i  input  1  data request is a write (1) or read (0).
REQ-012 The block SHALL have port d_addr_i  input  DEPTH  data word address.
REQ-013 The block SHALL have port d_wdata_i  input  WIDTH  data write value.
REQ-014 The block SHALL have port d_gnt_o  output  1  data request accepted this cycle.
REQ-015 The block SHALL have port d_rvalid_o  output  1  data read data valid.
REQ-016 The block SHALL have port d_rdata_o  output  WIDTH  data read data.
REQ-017 The block SHALL have ports mem_read_addr_o (DEPTH), mem_write_addr_o (DEPTH), mem_write_data_o (WIDTH), mem_write_enable_o (1) as outputs and mem_read_data_i (WIDTH) as input, all connecting to the one-read/one-write memory with 1-cycle registered read.

Function
REQ-018 Grants SHALL be combinational from requests and registered state; a request is accepted only in a cycle where its gnt is 1.
REQ-019 A data write (d_req_i=1, d_we_i=1) SHALL always be granted, driving mem_write_enable_o=1, mem_write_addr_o=d_addr_i, mem_write_data_o=d_wdata_i that cycle; mem_write_enable_o is 0 otherwise.
REQ-020 At most one read SHALL be granted per cycle; a data write and a fetch read may both be granted in the same cycle.
REQ-021 Read conflict (if_req_i=1 and data read requested): winner chosen by 1-bit round-robin pointer prio; prio=0 favours fetch, prio=1 favours data; loser's gnt is 0.
REQ-022 prio SHALL update only on a conflict cycle, to favour the loser next; non-conflict cycles leave it unchanged.
REQ-023 Hazard: if a data write and a fetch read to the same address are requested together, if_gnt_o SHALL be 0 that cycle (write granted, fetch retries).
REQ-024 mem_read_addr_o SHALL equal the granted read address; with no read granted it SHALL hold the last granted read address (register, reset 0).
REQ-025 Read latency SHALL be 1 cycle: the granted requester's rvalid is 1 exactly in the cycle after its gnt, with rdata = mem_read_data_i.
REQ-026 A 1-bit registered owner SHALL track which port a read was granted to; rvalid routes to that port only.
REQ-027 if_rdata_o/d_rdata_o SHALL be 0 whenever the respective rvalid is 0.
REQ-028 Back-to-back reads SHALL sustain one grant per cycle with no bubble.

Reset
REQ-029 While rst_i=1: if_gnt_o, d_gnt_o, mem_write_enable_o, if_rvalid_o, d_rvalid_o SHALL be 0; requests are ignored.
REQ-030 After reset: prio=0, read-address register=0, no pending rvalid, all rdata outputs 0.
REQ-031 rst_i asserted in the cycle after a grant SHALL suppress that grant's rvalid.

Verification
REQ-032 Fetch-only: if_req_i=1, if_addr_i=0x10, mem holds 0xDEADBEEF -> if_gnt_o=1 cycle N, if_rvalid_o=1, if_rdata_o=0xDEADBEEF cycle N+1.
REQ-033 Conflict x3: fetch addr 0x4 and data read addr 0x8 held 3 cycles from reset -> winners fetch, data, fetch; each rvalid on the matching port next cycle.
REQ-034 Parallel write+read: data write 0x20<-0x12345678 with fetch read 0x24 -> both granted, mem_write_enable_o=1, if_rvalid_o=1 next cycle.
REQ-035 Hazard: data write 0x30<-0xA5A5A5A5 with fetch read 0x30 -> if_gnt_o=0; next cycle fetch granted, following cycle if_rdata_o=0xA5A5A5A5.
REQ-036 Reset mid-read: data read granted cycle N, rst_i=1 cycle N+1 -> d_rvalid_o=0, all grants 0, prio=0 afterward.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Purpose : bundle of the fetch port, data port and 1R/1W memory signals seen by mem_arbiter.
// Latency : n/a (wiring only).
// Backpressure: requesters hold req until their gnt is seen; the memory side has none.
// Ports   : slave = arbiter side; master = requesters + memory side (testbench / SoC glue).
interface mem_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    // instruction-fetch port
    logic             if_req_i;
    logic [DEPTH-1:0] if_addr_i;
    logic             if_gnt_o;
    logic             if_rvalid_o;
    logic [WIDTH-1:0] if_rdata_o;
    // data port
    logic             d_req_i;
    logic             d_we_i;
    logic [DEPTH-1:0] d_addr_i;
    logic [WIDTH-1:0] d_wdata_i;
    logic             d_gnt_o;
    logic             d_rvalid_o;
    logic [WIDTH-1:0] d_rdata_o;
    // one-read/one-write memory, registered read
    logic [DEPTH-1:0] mem_read_addr_o;
    logic [DEPTH-1:0] mem_write_addr_o;
    logic [WIDTH-1:0] mem_write_data_o;
    logic             mem_write_enable_o;
    logic [WIDTH-1:0] mem_read_data_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_read_addr_o, mem_write_addr_o, mem_write_data_o, mem_write_enable_o,
        input  mem_read_data_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_read_addr_o, mem_write_addr_o, mem_write_data_o, mem_write_enable_o,
        output mem_read_data_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates a fetch port and a data port onto a 1R/1W memory (round-robin on read conflicts).
// Latency : grants combinational; read data/rvalid exactly 1 cycle after the grant.
// Backpressure: a losing or hazarded request sees gnt=0 and must hold; data writes are never stalled.
// Ports   : clk_i (rising edge), rst_i (sync, active-high), bus (mem_arbiter_if.slave: fetch, data, memory).
module mem_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    logic             prio_q;      // 0: fetch wins next conflict, 1: data wins
    logic [DEPTH-1:0] raddr_q;     // last granted read address
    logic             rd_vld_q;    // a read was granted last cycle
    owner_t           owner_q;     // which port that read belongs to

    logic d_wr;
    logic d_rd;
    logic hazard;
    logic rd_conflict;
    logic if_gnt;
    logic d_rd_gnt;
    logic rd_gnt;

    assign d_wr = bus.d_req_i & bus.d_we_i;
    assign d_rd = bus.d_req_i & ~bus.d_we_i;

    // A fetch reading the word being written this cycle would see stale data
    // (read-before-write memory), so the fetch is held off one cycle.
    assign hazard      = d_wr & bus.if_req_i & (bus.d_addr_i == bus.if_addr_i);
    assign rd_conflict = bus.if_req_i & d_rd;

    assign if_gnt   = ~rst_i & bus.if_req_i & ~hazard & ~(d_rd & prio_q);
    assign d_rd_gnt = ~rst_i & d_rd & ~(bus.if_req_i & ~prio_q);
    assign rd_gnt   = if_gnt | d_rd_gnt;

    assign bus.if_gnt_o = if_gnt;
    assign bus.d_gnt_o  = d_rd_gnt | (~rst_i & d_wr);

    assign bus.mem_write_enable_o = ~rst_i & d_wr;
    assign bus.mem_write_addr_o   = bus.d_addr_i;
    assign bus.mem_write_data_o   = bus.d_wdata_i;

    // Hold the previous address when idle so the memory read port stays quiet.
    assign bus.mem_read_addr_o = if_gnt   ? bus.if_addr_i :
                                 d_rd_gnt ? bus.d_addr_i  : raddr_q;

    // rst_i also masks the pending response combinationally so a reset in the
    // cycle after a grant kills that grant's rvalid.
    assign bus.if_rvalid_o = ~rst_i & rd_vld_q & (owner_q == OWN_IF);
    assign bus.d_rvalid_o  = ~rst_i & rd_vld_q & (owner_q == OWN_D);
    assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_read_data_i : {WIDTH{1'b0}};
    assign bus.d_rdata_o   = bus.d_rvalid_o  ? bus.mem_read_data_i : {WIDTH{1'b0}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q   <= 1'b0;
            raddr_q  <= '0;
            rd_vld_q <= 1'b0;
            owner_q  <= OWN_IF;
        end else begin
            // favour whichever side lost this conflict
            if (rd_conflict) begin
                prio_q <= ~prio_q;
            end
            if (rd_gnt) begin
                raddr_q <= bus.mem_read_addr_o;
            end
            rd_vld_q <= rd_gnt;
            owner_q  <= d_rd_gnt ? OWN_D : OWN_IF;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(32), .DEPTH(32)) bus ();

    mem_arbiter #(.WIDTH(32), .DEPTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] pat(input int a);
        return (a == 16) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(a);
    endfunction

    // memory with 1-cycle registered read, reloaded with the pattern on reset
    logic [31:0] mem [0:63];
    logic [31:0] mem_rd_q;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
        end else if (bus.mem_write_enable_o) begin
            mem[bus.mem_write_addr_o[5:0]] <= bus.mem_write_data_o;
        end
        mem_rd_q <= mem[bus.mem_read_addr_o[5:0]];
    end

    assign bus.mem_read_data_i = mem_rd_q;

    // reference model state
    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [0:63];
    bit          prio_m;
    logic [31:0] last_m;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check comb/registered outputs, then advance.
    task automatic drive(input bit r, input bit ireq, input logic [31:0] iaddr,
                         input bit dreq, input bit dwe, input logic [31:0] daddr,
                         input logic [31:0] wdata, input string tag);
        bit          d_wr, d_rd, hz, conf;
        bit          exp_ig, exp_dg, exp_we, exp_iv, exp_dv;
        logic [31:0] exp_ra, exp_idat, exp_ddat;
        exp_t        e;

        rst           = r;
        bus.if_req_i  = ireq;
        bus.if_addr_i = iaddr;
        bus.d_req_i   = dreq;
        bus.d_we_i    = dwe;
        bus.d_addr_i  = daddr;
        bus.d_wdata_i = wdata;
        #1;

        d_wr = dreq && dwe;
        d_rd = dreq && !dwe;
        hz   = d_wr && ireq && (iaddr == daddr);
        conf = ireq && d_rd;
        exp_ig = 1'b0;
        exp_dg = 1'b0;
        exp_we = 1'b0;
        if (!r) begin
            exp_we = d_wr;
            if (conf) begin
                if (!prio_m) exp_ig = 1'b1;
                else         exp_dg = 1'b1;
            end else begin
                exp_ig = ireq && !hz;
                exp_dg = d_rd;
            end
            if (d_wr) exp_dg = 1'b1;
        end
        if (exp_ig)              exp_ra = iaddr;
        else if (exp_dg && d_rd) exp_ra = daddr;
        else                     exp_ra = last_m;

        exp_iv = 1'b0;
        exp_dv = 1'b0;
        exp_idat = '0;
        exp_ddat = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!r) begin
                if (e.is_d) begin exp_dv = 1'b1; exp_ddat = e.data; end
                else        begin exp_iv = 1'b1; exp_idat = e.data; end
            end
        end

        chk({tag, "_if_gnt"},   32'(bus.if_gnt_o),           32'(exp_ig));
        chk({tag, "_d_gnt"},    32'(bus.d_gnt_o),            32'(exp_dg));
        chk({tag, "_we"},       32'(bus.mem_write_enable_o), 32'(exp_we));
        chk({tag, "_raddr"},    bus.mem_read_addr_o,         exp_ra);
        chk({tag, "_if_rvld"},  32'(bus.if_rvalid_o),        32'(exp_iv));
        chk({tag, "_d_rvld"},   32'(bus.d_rvalid_o),         32'(exp_dv));
        chk({tag, "_if_rdata"}, bus.if_rdata_o,              exp_idat);
        chk({tag, "_d_rdata"},  bus.d_rdata_o,               exp_ddat);
        if (exp_we) begin
            chk({tag, "_waddr"}, bus.mem_write_addr_o, daddr);
            chk({tag, "_wdata"}, bus.mem_write_data_o, wdata);
        end

        if (exp_ig)              sb.push_back('{1'b0, ref_mem[iaddr[5:0]]});
        else if (exp_dg && d_rd) sb.push_back('{1'b1, ref_mem[daddr[5:0]]});

        @(posedge clk);
        if (r) begin
            prio_m = 1'b0;
            last_m = '0;
            for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
        end else begin
            if (conf) prio_m = !prio_m;
            if (exp_ig || (exp_dg && d_rd)) last_m = exp_ra;
            if (exp_we) ref_mem[daddr[5:0]] = wdata;
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, tag);
    endtask

    initial begin
        bus.if_req_i  = 1'b0;
        bus.if_addr_i = '0;
        bus.d_req_i   = 1'b0;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = '0;
        bus.d_wdata_i = '0;
        prio_m = 1'b0;
        last_m = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
        repeat (2) @(negedge clk);

        // reset: requests ignored, outputs quiet
        drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h11, 32'h55, "rst0");
        drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h11, 32'h0,  "rst1");
        idle("post_rst");

        // fetch-only read of 0x10 -> DEADBEEF next cycle
        drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, "fetch");
        idle("fetch_rsp");
        chk("fetch_deadbeef_seen", ref_mem[16], 32'hDEADBEEF);

        // three-cycle conflict from reset: fetch, data, fetch
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "rst_c");
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, $sformatf("conf%0d", i));
        idle("conf_rsp");

        // parallel write + fetch read
        drive(1'b0, 1'b1, 32'h24, 1'b1, 1'b1, 32'h20, 32'h12345678, "par");
        idle("par_rsp");
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, "par_rdback");
        idle("par_rdback_rsp");

        // hazard: fetch of the address being written waits one cycle
        drive(1'b0, 1'b1, 32'h30, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, "haz");
        drive(1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 32'h0,  32'h0,        "haz_retry");
        idle("haz_rsp");

        // back-to-back reads, no bubble
        drive(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h10, 32'h0, "b2b0");
        drive(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0, "b2b1");
        drive(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h30, 32'h0, "b2b2");
        drive(1'b0, 1'b1, 32'h3,  1'b0, 1'b0, 32'h0,  32'h0, "b2b3");
        idle("b2b_rsp");

        // reset right after a data-read grant: response suppressed, prio back to 0
        drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, "pre_mid");
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, "rdmid");
        drive(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, "rstmid");
        drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, "postmid");
        idle("postmid_rsp");

        // random traffic
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 40) == 0),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 15)), $urandom, "rnd");
        end
        idle("drain");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
